// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the ECE-271 multi-cycle control unit:
// FSM states, opcode and ALU encodings, the decoded instruction class and
// the bundle of registered datapath controls.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b0001;
    localparam logic [3:0] OP_LDW  = 4'b0010;
    localparam logic [3:0] OP_STW  = 4'b0011;
    localparam logic [3:0] OP_RTR  = 4'b0100;
    localparam logic [3:0] OP_BLT  = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_SUB    = 2'd1;
    localparam logic [1:0] ALU_PASS_A = 2'd2;

    // Instruction class after decoding; illegal encodings collapse to one value.
    typedef enum logic [3:0] {
        K_NOP     = 4'd0,
        K_JMP     = 4'd1,
        K_LDW     = 4'd2,
        K_STW     = 4'd3,
        K_RTR     = 4'd4,
        K_BLT     = 4'd5,
        K_ADD     = 4'd6,
        K_SUB     = 4'd7,
        K_HALT    = 4'd8,
        K_ILLEGAL = 4'd9
    } op_kind_t;

    // Datapath controls that depend only on state and the stored opcode.
    typedef struct packed {
        logic [1:0] alu;
        logic       pc_en;
        logic       pc_in_op;
        logic       pc_or_read_mem;
        logic       read_1_en;
        logic       read_2_en;
        logic       reg_file_wr_en;
        logic       write_reg_from_memory;
        logic       en_mem_add;
        logic       mem_req;
        logic       ram_wr_en;
        logic       halted;
    } ctrl_out_t;

    // Map the low opcode nibble to an instruction class; any set upper bit is illegal.
    function automatic op_kind_t classify_op(input logic [3:0] low, input logic upper_nz);
        op_kind_t k;
        k = K_ILLEGAL;
        if (upper_nz) begin
            k = K_ILLEGAL;
        end else begin
            case (low)
                OP_NOP:  k = K_NOP;
                OP_JMP:  k = K_JMP;
                OP_LDW:  k = K_LDW;
                OP_STW:  k = K_STW;
                OP_RTR:  k = K_RTR;
                OP_BLT:  k = K_BLT;
                OP_ADD:  k = K_ADD;
                OP_SUB:  k = K_SUB;
                OP_HALT: k = K_HALT;
                default: k = K_ILLEGAL;
            endcase
        end
        return k;
    endfunction

    // ALU operation for the instruction classes that use the ALU.
    function automatic logic [1:0] alu_code(input op_kind_t k);
        logic [1:0] a;
        case (k)
            K_SUB:   a = ALU_SUB;
            K_BLT:   a = ALU_SUB;
            K_RTR:   a = ALU_PASS_A;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Moore part of the control decode: everything that is a function of state and class.
    function automatic ctrl_out_t decode_outs(input state_t st, input op_kind_t k);
        ctrl_out_t o;
        o = '0;
        case (st)
            FETCH: begin
                o.mem_req = 1'b1;
            end
            DECODE: begin
                o.read_1_en = 1'b1;
                o.read_2_en = 1'b1;
            end
            EXEC: begin
                case (k)
                    K_ADD, K_SUB, K_RTR, K_BLT: begin
                        // operands stay on the ALU inputs while it computes
                        o.alu       = alu_code(k);
                        o.read_1_en = 1'b1;
                        o.read_2_en = 1'b1;
                    end
                    K_JMP: begin
                        o.pc_en    = 1'b1;
                        o.pc_in_op = 1'b1;
                    end
                    K_LDW, K_STW: begin
                        o.en_mem_add = 1'b1;
                    end
                    default: begin
                        o.alu = ALU_ADD;
                    end
                endcase
            end
            MEM: begin
                o.mem_req        = 1'b1;
                o.pc_or_read_mem = 1'b1;
                o.ram_wr_en      = (k == K_STW);
            end
            WB: begin
                // keep the ALU op so the write-back data stays stable
                o.alu                   = alu_code(k);
                o.reg_file_wr_en        = 1'b1;
                o.write_reg_from_memory = (k == K_LDW);
            end
            HALT: begin
                o.halted = 1'b1;
            end
            default: begin
                o.alu = ALU_ADD;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/control_fsm_mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for mem_ready.
// clear restarts the count, count advances it (saturating), expired flags the
// configured limit. A limit of 0 never expires.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    logic [TO_W-1:0] cnt_r;

    // Wait counter: clear has priority, saturates instead of wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (count && (cnt_r != {TO_W{1'b1}})) begin
            cnt_r <= cnt_r + TO_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (MEM_TIMEOUT != 32'sd0) && (cnt_r == TO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the ECE-271 CPU.
// States IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT; memory handshake with timeout.
// Optional feature macro ILLEGAL_OP_TRAP_EN: adds the illegal_op output and
// traps illegal opcodes in EXEC into HALT instead of executing them as NOP.
// Controls are registered from the next state; only the FETCH completion
// (pc_en/ir_en) and the taken-branch PC load in EXEC follow inputs directly.
module control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int ALU_CTRL_W  = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  lt_flag,
    input  logic                  mem_ready,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  pc_en,
    output logic                  pc_in_op,
    output logic                  pc_or_read_mem,
    output logic                  ir_en,
    output logic                  read_1_en,
    output logic                  read_2_en,
    output logic                  reg_file_wr_en,
    output logic                  write_reg_from_memory,
    output logic                  en_mem_add,
    output logic                  mem_req,
    output logic                  ram_wr_en,
    output logic                  lt_state,
    output logic                  halted,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic                  illegal_op,
`endif
    output logic                  mem_timeout
);

    state_t              state_r;
    state_t              state_next_s;
    logic [OPCODE_W-1:0] opcode_store_r;
    op_kind_t            kind_cur_s;
    op_kind_t            kind_next_s;
    ctrl_out_t           outs_r;
    logic                lt_state_r;
    logic                mem_timeout_r;
    logic                in_mem_wait_s;
    logic                fetch_done_s;
    logic                blt_take_s;
    logic                timeout_fire_s;
    logic                trap_fire_s;
    logic                timer_clear_s;
    logic                timer_count_s;
    logic                timer_expired_s;
`ifdef ILLEGAL_OP_TRAP_EN
    logic                illegal_op_r;
`endif

    function automatic logic upper_bits_set(input logic [OPCODE_W-1:0] op);
        return (op >> 3'd4) != {OPCODE_W{1'b0}};
    endfunction

    // Instruction class of the stored opcode, and of the opcode about to be stored.
    always_comb begin
        kind_cur_s  = classify_op(opcode_store_r[3:0], upper_bits_set(opcode_store_r));
        kind_next_s = kind_cur_s;
        if (state_r == DECODE) begin
            kind_next_s = classify_op(opcode[3:0], upper_bits_set(opcode));
        end else begin
            kind_next_s = kind_cur_s;
        end
    end

    // Handshake, branch and trap conditions derived from the current state.
    always_comb begin
        in_mem_wait_s  = (state_r == FETCH) || (state_r == MEM);
        fetch_done_s   = (state_r == FETCH) && mem_ready;
        blt_take_s     = (state_r == EXEC) && (kind_cur_s == K_BLT) && lt_flag;
        timer_count_s  = in_mem_wait_s && !mem_ready;
        // mem_ready in the limit cycle completes normally
        timeout_fire_s = in_mem_wait_s && !mem_ready && timer_expired_s;
`ifdef ILLEGAL_OP_TRAP_EN
        trap_fire_s    = (state_r == EXEC) && (kind_cur_s == K_ILLEGAL);
`else
        trap_fire_s    = 1'b0;
`endif
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    state_next_s = DECODE;
                end else if (timer_expired_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: state_next_s = EXEC;
            EXEC: begin
                case (kind_cur_s)
                    K_ADD, K_SUB, K_RTR: state_next_s = WB;
                    K_LDW, K_STW:        state_next_s = MEM;
                    K_HALT:              state_next_s = HALT;
                    K_ILLEGAL:           state_next_s = trap_fire_s ? HALT : FETCH;
                    default:             state_next_s = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    state_next_s = (kind_cur_s == K_LDW) ? WB : FETCH;
                end else if (timer_expired_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = MEM;
                end
            end
            WB:      state_next_s = FETCH;
            HALT:    state_next_s = HALT;
            default: state_next_s = IDLE;
        endcase
    end

    // Every state change restarts the wait count, covering entry to FETCH and MEM.
    assign timer_clear_s = (state_next_s != state_r);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_mem_wait_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear_s),
        .count   (timer_count_s),
        .expired (timer_expired_s)
    );

    // FSM: state, opcode/flag latches, sticky status and registered controls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            opcode_store_r <= {OPCODE_W{1'b0}};
            lt_state_r     <= 1'b0;
            mem_timeout_r  <= 1'b0;
            outs_r         <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_op_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            outs_r  <= decode_outs(state_next_s, kind_next_s);
            if (state_r == DECODE) begin
                opcode_store_r <= opcode;
            end else begin
                opcode_store_r <= opcode_store_r;
            end
            if ((state_r == EXEC) && (kind_cur_s == K_BLT)) begin
                lt_state_r <= lt_flag;
            end else begin
                lt_state_r <= lt_state_r;
            end
            if (timeout_fire_s) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            if (trap_fire_s) begin
                illegal_op_r <= 1'b1;
            end else begin
                illegal_op_r <= illegal_op_r;
            end
`endif
        end
    end

    // Output drive: registered controls plus the two handshake/branch-driven PC terms.
    always_comb begin
        alu_control           = ALU_CTRL_W'(outs_r.alu);
        pc_en                 = outs_r.pc_en | fetch_done_s | blt_take_s;
        pc_in_op              = outs_r.pc_in_op | blt_take_s;
        pc_or_read_mem        = outs_r.pc_or_read_mem;
        ir_en                 = fetch_done_s;
        read_1_en             = outs_r.read_1_en;
        read_2_en             = outs_r.read_2_en;
        reg_file_wr_en        = outs_r.reg_file_wr_en;
        write_reg_from_memory = outs_r.write_reg_from_memory;
        en_mem_add            = outs_r.en_mem_add;
        mem_req               = outs_r.mem_req;
        ram_wr_en             = outs_r.ram_wr_en;
        lt_state              = lt_state_r;
        halted                = outs_r.halted;
        mem_timeout           = mem_timeout_r;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_op            = illegal_op_r;
`endif
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed testbench for control_fsm (MEM_TIMEOUT=4). Covers reset state,
// ADD/LDW/BLT flows, the timeout limit boundary, timeout HALT, asynchronous
// reset mid-request and illegal opcode handling (with or without ILLEGAL_OP_TRAP_EN).
module tb_control_fsm;
    import cpu_ctrl_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [3:0] opcode;
    logic       lt_flag;
    logic       mem_ready;
    logic [1:0] alu_control;
    logic       pc_en;
    logic       pc_in_op;
    logic       pc_or_read_mem;
    logic       ir_en;
    logic       read_1_en;
    logic       read_2_en;
    logic       reg_file_wr_en;
    logic       write_reg_from_memory;
    logic       en_mem_add;
    logic       mem_req;
    logic       ram_wr_en;
    logic       lt_state;
    logic       halted;
    logic       mem_timeout;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int cnt;

    state_t exp_add[5] = '{FETCH, DECODE, EXEC, WB, FETCH};

    control_fsm #(
        .OPCODE_W    (4),
        .ALU_CTRL_W  (2),
        .MEM_TIMEOUT (4),
        .TO_W        (3)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .start                 (start),
        .opcode                (opcode),
        .lt_flag               (lt_flag),
        .mem_ready             (mem_ready),
        .alu_control           (alu_control),
        .pc_en                 (pc_en),
        .pc_in_op              (pc_in_op),
        .pc_or_read_mem        (pc_or_read_mem),
        .ir_en                 (ir_en),
        .read_1_en             (read_1_en),
        .read_2_en             (read_2_en),
        .reg_file_wr_en        (reg_file_wr_en),
        .write_reg_from_memory (write_reg_from_memory),
        .en_mem_add            (en_mem_add),
        .mem_req               (mem_req),
        .ram_wr_en             (ram_wr_en),
        .lt_state              (lt_state),
        .halted                (halted),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op            (illegal_op),
`endif
        .mem_timeout           (mem_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        opcode    = 4'b0000;
        lt_flag   = 1'b0;
        mem_ready = 1'b0;

        // Reset state
        #12;
        check_val("rst_state", 32'(dut.state_r), 32'(IDLE));
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_alu", 32'(alu_control), 32'd0);
        check_val("rst_pc_en", 32'(pc_en), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_mem_timeout", 32'(mem_timeout), 32'd0);
        check_val("rst_lt_state", 32'(lt_state), 32'd0);
`ifdef ILLEGAL_OP_TRAP_EN
        check_val("rst_illegal_op", 32'(illegal_op), 32'd0);
`endif
        nxt();
        reset_n = 1'b1;

        // ADD with memory always ready
        start     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 4'b0110;
        nxt();
        start = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nxt();
            #2;
            check_val($sformatf("add_state%0d", i), 32'(dut.state_r), 32'(exp_add[i]));
            cnt += int'(reg_file_wr_en);
            if (i == 0) begin
                check_val("add_fetch_ir_en", 32'(ir_en), 32'd1);
                check_val("add_fetch_pc_en", 32'(pc_en), 32'd1);
                check_val("add_fetch_mem_req", 32'(mem_req), 32'd1);
                check_val("add_fetch_addr_sel", 32'(pc_or_read_mem), 32'd0);
            end
            if (i == 2) check_val("add_exec_alu", 32'(alu_control), 32'd0);
        end
        check_val("add_wr_cycles", 32'(cnt), 32'd1);

        // LDW, mem_ready arrives in the 4th MEM cycle
        opcode = 4'b0010;
        nxt();
        nxt();
        #2;
        check_val("ldw_exec_en_mem_add", 32'(en_mem_add), 32'd1);
        mem_ready = 1'b0;
        nxt();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            mem_ready = (i == 3);
            #2;
            if (dut.state_r == MEM && mem_req && pc_or_read_mem && !ram_wr_en) cnt++;
        end
        check_val("ldw_mem_cycles", 32'(cnt), 32'd4);
        nxt();
        #2;
        check_val("ldw_wb_state", 32'(dut.state_r), 32'(WB));
        check_val("ldw_wb_from_mem", 32'(write_reg_from_memory), 32'd1);
        check_val("ldw_wb_wr_en", 32'(reg_file_wr_en), 32'd1);

        // Fetch for BLT: mem_ready only in the cycle the count equals the limit
        mem_ready = 1'b0;
        opcode    = 4'b0101;
        lt_flag   = 1'b1;
        nxt();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nxt();
            mem_ready = (i == 4);
            #2;
        end
        check_val("limit_ready_ir_en", 32'(ir_en), 32'd1);
        nxt();
        #2;
        check_val("limit_ready_state", 32'(dut.state_r), 32'(DECODE));
        check_val("limit_ready_no_timeout", 32'(mem_timeout), 32'd0);

        // BLT taken
        nxt();
        #2;
        check_val("blt1_pc_en", 32'(pc_en), 32'd1);
        check_val("blt1_pc_in_op", 32'(pc_in_op), 32'd1);
        check_val("blt1_alu", 32'(alu_control), 32'd1);
        nxt();
        #2;
        check_val("blt1_state", 32'(dut.state_r), 32'(FETCH));
        check_val("blt1_lt_state", 32'(lt_state), 32'd1);

        // BLT not taken
        lt_flag = 1'b0;
        nxt();
        nxt();
        #2;
        check_val("blt0_pc_en", 32'(pc_en), 32'd0);
        check_val("blt0_pc_in_op", 32'(pc_in_op), 32'd0);
        nxt();
        #2;
        check_val("blt0_lt_state", 32'(lt_state), 32'd0);

        // STW interrupted by asynchronous reset in MEM
        opcode = 4'b0011;
        nxt();
        nxt();
        mem_ready = 1'b0;
        nxt();
        #2;
        check_val("stw_mem_req", 32'(mem_req), 32'd1);
        check_val("stw_ram_wr_en", 32'(ram_wr_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("stw_rst_mem_req", 32'(mem_req), 32'd0);
        check_val("stw_rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        check_val("stw_rst_state", 32'(dut.state_r), 32'(IDLE));
        nxt();
        reset_n = 1'b1;

        // Illegal opcode 1010
        start     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 4'b1010;
        nxt();
        start = 1'b0;
        nxt();
        nxt();
        nxt();
        #2;
`ifdef ILLEGAL_OP_TRAP_EN
        check_val("illegal_state", 32'(dut.state_r), 32'(HALT));
        check_val("illegal_op_flag", 32'(illegal_op), 32'd1);
        check_val("illegal_halted", 32'(halted), 32'd1);
`else
        check_val("illegal_state", 32'(dut.state_r), 32'(FETCH));
        check_val("illegal_no_wr", 32'(reg_file_wr_en), 32'd0);
`endif
        reset_n = 1'b0;
        nxt();
        reset_n = 1'b1;

        // Fetch timeout: mem_ready never arrives
        start     = 1'b1;
        mem_ready = 1'b0;
        nxt();
        start = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nxt();
            #2;
            if (dut.state_r == FETCH) cnt++;
        end
        check_val("to_fetch_cycles", 32'(cnt), 32'd5);
        nxt();
        #2;
        check_val("to_state", 32'(dut.state_r), 32'(HALT));
        check_val("to_halted", 32'(halted), 32'd1);
        check_val("to_mem_timeout", 32'(mem_timeout), 32'd1);
        check_val("to_mem_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            start     = (i % 2 == 0);
            mem_ready = 1'b1;
            nxt();
        end
        start = 1'b0;
        #2;
        check_val("to_stay_state", 32'(dut.state_r), 32'(HALT));
        check_val("to_stay_halted", 32'(halted), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
